// File: rtl/qracc_csr_bank.sv
`default_nettype none
// ============================================================================
//  Module      : qracc_csr_bank
//  Description : Host-facing CSR bank for the qracc controller. Holds CSR0
//                (main control/status) plus NUM_CFG_CSR double-buffered config
//                CSRs. The shadow set is committed atomically to the active
//                outputs when a trigger is accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
module qracc_csr_bank #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int NUM_CFG_CSR = 6,
    parameter int TRIG_W      = 3,
    parameter int STATE_W     = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ctrl_valid_i,
    input  logic                          ctrl_wen_i,
    input  logic [ADDR_W-1:0]             ctrl_addr_i,
    input  logic [DATA_W-1:0]             ctrl_data_i,
    output logic                          ctrl_ready_o,
    output logic [DATA_W-1:0]             ctrl_read_data_o,
    input  logic                          busy_i,
    input  logic [STATE_W-1:0]            state_i,
    output logic [TRIG_W-1:0]             trigger_o,
    output logic                          trigger_valid_o,
    output logic                          clear_o,
    output logic                          inst_write_mode_o,
    output logic [NUM_CFG_CSR*DATA_W-1:0] active_cfg_o,
    output logic                          err_o
);

    // Word index is the byte address with the intra-word offset dropped.
    localparam int c_IDX_SHIFT = $clog2(DATA_W / 8);

    // CSR0 bit positions
    localparam int c_BIT_CLEAR = 3;
    localparam int c_BIT_BUSY  = 4;
    localparam int c_BIT_IWM   = 5;
    localparam int c_BIT_STATE = 8;
    localparam int c_BIT_ERR   = 12;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [DATA_W-1:0]   r_shadow [NUM_CFG_CSR];
    logic [DATA_W-1:0]   r_active [NUM_CFG_CSR];
    logic [DATA_W-1:0]   r_rd_data;
    logic [TRIG_W-1:0]   r_trig_code;
    logic                r_trig_valid;
    logic                r_clear;
    logic                r_err;
    logic                r_iwm;

    logic                w_capture;
    logic [ADDR_W-1:0]   w_idx;
    logic                w_is_csr0;
    logic                w_oor;
    logic                w_csr0_wr;
    logic                w_clear_req;
    logic                w_trig_req;
    logic                w_trig_accept;
    logic                w_trig_reject;
    logic                w_err_set;
    logic [DATA_W-1:0]   w_rd_data;

    assign w_capture     = (r_state == S_IDLE) && ctrl_valid_i;
    assign w_idx         = ctrl_addr_i >> c_IDX_SHIFT;
    assign w_is_csr0     = (w_idx == '0);
    assign w_oor         = (w_idx > ADDR_W'(NUM_CFG_CSR));
    assign w_csr0_wr     = w_capture && ctrl_wen_i && w_is_csr0;
    // Clear takes precedence over a trigger written in the same word.
    assign w_clear_req   = w_csr0_wr && ctrl_data_i[c_BIT_CLEAR];
    assign w_trig_req    = w_csr0_wr && !ctrl_data_i[c_BIT_CLEAR]
                           && (ctrl_data_i[TRIG_W-1:0] != '0);
    assign w_trig_accept = w_trig_req && !busy_i;
    assign w_trig_reject = w_trig_req && busy_i;
    assign w_err_set     = (w_capture && w_oor) || w_trig_reject;

    // Response handshake: one RESP cycle after every captured request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic for the request/response sequencer.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (ctrl_valid_i) w_state_next = S_RESP;
            S_RESP:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Read mux: CSR0 status view or shadow config; out-of-range reads return 0.
    always_comb begin
        w_rd_data = '0;
        if (w_is_csr0) begin
            w_rd_data[c_BIT_BUSY]                 = busy_i;
            w_rd_data[c_BIT_IWM]                  = r_iwm;
            w_rd_data[c_BIT_STATE +: STATE_W]     = state_i;
            w_rd_data[c_BIT_ERR]                  = r_err;
        end else begin
            for (int k = 0; k < NUM_CFG_CSR; k++) begin
                if (w_idx == ADDR_W'(k + 1)) begin
                    w_rd_data = r_shadow[k];
                end
            end
        end
    end

    // Shadow config writes land on the capture edge regardless of busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_CFG_CSR; k++) begin
                r_shadow[k] <= '0;
            end
        end else if (w_capture && ctrl_wen_i) begin
            for (int k = 0; k < NUM_CFG_CSR; k++) begin
                if (w_idx == ADDR_W'(k + 1)) begin
                    r_shadow[k] <= ctrl_data_i;
                end
            end
        end
    end

    // Atomic commit of the whole shadow set on an accepted trigger.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_CFG_CSR; k++) begin
                r_active[k] <= '0;
            end
        end else if (w_trig_accept) begin
            for (int k = 0; k < NUM_CFG_CSR; k++) begin
                r_active[k] <= r_shadow[k];
            end
        end
    end

    // CSR0 stored field, sticky error and the pulses/read data shown in RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_iwm        <= 1'b0;
            r_err        <= 1'b0;
            r_rd_data    <= '0;
            r_trig_code  <= '0;
            r_trig_valid <= 1'b0;
            r_clear      <= 1'b0;
        end else begin
            if (w_csr0_wr) begin
                r_iwm <= ctrl_data_i[c_BIT_IWM];
            end
            if (w_clear_req) begin
                r_err <= 1'b0;
            end else if (w_err_set) begin
                r_err <= 1'b1;
            end
            r_rd_data    <= (w_capture && !ctrl_wen_i) ? w_rd_data : '0;
            r_trig_valid <= w_trig_accept;
            r_trig_code  <= w_trig_accept ? ctrl_data_i[TRIG_W-1:0] : '0;
            r_clear      <= w_clear_req;
        end
    end

    // Flatten active CSRs: config CSR k+1 sits in slice k.
    generate
        for (genvar gk = 0; gk < NUM_CFG_CSR; gk++) begin : g_active_pack
            assign active_cfg_o[gk*DATA_W +: DATA_W] = r_active[gk];
        end
    endgenerate

    assign ctrl_ready_o      = (r_state == S_RESP);
    assign ctrl_read_data_o  = r_rd_data;
    assign trigger_o         = r_trig_code;
    assign trigger_valid_o   = r_trig_valid;
    assign clear_o           = r_clear;
    assign inst_write_mode_o = r_iwm;
    assign err_o             = r_err;

endmodule
`default_nettype wire

// File: tb/tb_qracc_csr_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_qracc_csr_bank
//  Description : Directed self-checking bench for qracc_csr_bank.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_qracc_csr_bank;

    localparam int c_DATA_W = 32;
    localparam int c_ADDR_W = 32;
    localparam int c_NCFG   = 6;
    localparam int c_TRIG_W = 3;
    localparam int c_STATE_W = 4;

    logic                        clk;
    logic                        rst;
    logic                        ctrl_valid_i;
    logic                        ctrl_wen_i;
    logic [c_ADDR_W-1:0]         ctrl_addr_i;
    logic [c_DATA_W-1:0]         ctrl_data_i;
    logic                        ctrl_ready_o;
    logic [c_DATA_W-1:0]         ctrl_read_data_o;
    logic                        busy_i;
    logic [c_STATE_W-1:0]        state_i;
    logic [c_TRIG_W-1:0]         trigger_o;
    logic                        trigger_valid_o;
    logic                        clear_o;
    logic                        inst_write_mode_o;
    logic [c_NCFG*c_DATA_W-1:0]  active_cfg_o;
    logic                        err_o;

    int n_checks;
    int n_fail;

    // Snapshot of outputs in the RESP cycle of the last transfer
    logic        s_ready;
    logic [31:0] s_rdata;
    logic        s_tv;
    logic [2:0]  s_trig;
    logic        s_clr;
    logic        s_err;
    logic [31:0] s_act_lo;
    logic [31:0] s_act_hi;

    qracc_csr_bank #(
        .DATA_W      (c_DATA_W),
        .ADDR_W      (c_ADDR_W),
        .NUM_CFG_CSR (c_NCFG),
        .TRIG_W      (c_TRIG_W),
        .STATE_W     (c_STATE_W)
    ) u_dut (
        .clk               (clk),
        .rst               (rst),
        .ctrl_valid_i      (ctrl_valid_i),
        .ctrl_wen_i        (ctrl_wen_i),
        .ctrl_addr_i       (ctrl_addr_i),
        .ctrl_data_i       (ctrl_data_i),
        .ctrl_ready_o      (ctrl_ready_o),
        .ctrl_read_data_o  (ctrl_read_data_o),
        .busy_i            (busy_i),
        .state_i           (state_i),
        .trigger_o         (trigger_o),
        .trigger_valid_o   (trigger_valid_o),
        .clear_o           (clear_o),
        .inst_write_mode_o (inst_write_mode_o),
        .active_cfg_o      (active_cfg_o),
        .err_o             (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One host transfer; the RESP-cycle outputs are snapshotted, then the
    // bench waits until the sequencer is back in IDLE.
    task automatic xfer(input logic wen, input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        ctrl_valid_i = 1'b1;
        ctrl_wen_i   = wen;
        ctrl_addr_i  = addr;
        ctrl_data_i  = data;
        @(posedge clk);
        #1;
        s_ready  = ctrl_ready_o;
        s_rdata  = ctrl_read_data_o;
        s_tv     = trigger_valid_o;
        s_trig   = trigger_o;
        s_clr    = clear_o;
        s_err    = err_o;
        s_act_lo = active_cfg_o[31:0];
        s_act_hi = active_cfg_o[191:160];
        check("ack_latency", {63'b0, s_ready}, 64'd1);
        ctrl_valid_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst          = 1'b1;
        ctrl_valid_i = 1'b0;
        ctrl_wen_i   = 1'b0;
        ctrl_addr_i  = '0;
        ctrl_data_i  = '0;
        busy_i       = 1'b0;
        state_i      = '0;
        repeat (3) @(negedge clk);
        check("rst_ready",  {63'b0, ctrl_ready_o}, 64'd0);
        check("rst_tvalid", {63'b0, trigger_valid_o}, 64'd0);
        check("rst_active", active_cfg_o[63:0], 64'd0);
        check("rst_err",    {63'b0, err_o}, 64'd0);
        rst = 1'b0;

        // Shadow write/read; active untouched
        xfer(1'b1, 32'h04, 32'h0000_1234);
        check("wr_cfg1_active", {32'b0, s_act_lo}, 64'd0);
        xfer(1'b0, 32'h04, 32'h0);
        check("rd_cfg1", {32'b0, s_rdata}, 64'h1234);
        xfer(1'b0, 32'h06, 32'h0);
        check("rd_cfg1_lowbits", {32'b0, s_rdata}, 64'h1234);

        // Accepted trigger commits shadow in the pulse cycle
        xfer(1'b1, 32'h00, 32'h3);
        check("trig_valid", {63'b0, s_tv}, 64'd1);
        check("trig_code",  {61'b0, s_trig}, 64'd3);
        check("trig_commit", {32'b0, s_act_lo}, 64'h1234);
        check("trig_valid_after", {63'b0, trigger_valid_o}, 64'd0);
        check("trig_code_after",  {61'b0, trigger_o}, 64'd0);

        // Busy: shadow updates, trigger rejected, err set
        busy_i = 1'b1;
        xfer(1'b1, 32'h04, 32'h0000_ABCD);
        xfer(1'b1, 32'h00, 32'h3);
        check("rej_tvalid", {63'b0, s_tv}, 64'd0);
        check("rej_active", {32'b0, s_act_lo}, 64'h1234);
        check("rej_err",    {63'b0, s_err}, 64'd1);
        xfer(1'b0, 32'h00, 32'h0);
        check("rd_csr0_busy_err", {32'b0, s_rdata}, 64'h1010);
        xfer(1'b0, 32'h04, 32'h0);
        check("rd_shadow_not_active", {32'b0, s_rdata}, 64'hABCD);

        // Clear wins over trigger
        busy_i = 1'b0;
        xfer(1'b1, 32'h00, 32'h0B);
        check("clr_pulse",  {63'b0, s_clr}, 64'd1);
        check("clr_no_trig", {63'b0, s_tv}, 64'd0);
        check("clr_err",    {63'b0, s_err}, 64'd0);
        check("clr_no_commit", {32'b0, s_act_lo}, 64'h1234);
        check("clr_after",  {63'b0, clear_o}, 64'd0);

        // Last config CSR and full-set commit
        xfer(1'b1, 32'h18, 32'h66);
        xfer(1'b1, 32'h00, 32'h5);
        check("trig5_code",  {61'b0, s_trig}, 64'd5);
        check("trig5_lo",    {32'b0, s_act_lo}, 64'hABCD);
        check("trig5_hi",    {32'b0, s_act_hi}, 64'h66);

        // inst_write_mode bit
        xfer(1'b1, 32'h00, 32'h20);
        check("iwm_out", {63'b0, inst_write_mode_o}, 64'd1);
        xfer(1'b0, 32'h00, 32'h0);
        check("rd_csr0_iwm", {32'b0, s_rdata}, 64'h20);
        xfer(1'b1, 32'h00, 32'h0);

        // Out-of-range accesses
        xfer(1'b0, 32'h1C, 32'h0);
        check("oor_rdata", {32'b0, s_rdata}, 64'd0);
        check("oor_err",   {63'b0, s_err}, 64'd1);
        xfer(1'b1, 32'h1C, 32'hFFFF);
        xfer(1'b0, 32'h18, 32'h0);
        check("oor_wr_cfg6", {32'b0, s_rdata}, 64'h66);
        xfer(1'b0, 32'h04, 32'h0);
        check("oor_wr_cfg1", {32'b0, s_rdata}, 64'hABCD);
        state_i = 4'h5;
        xfer(1'b0, 32'h00, 32'h0);
        check("rd_csr0_state", {32'b0, s_rdata}, 64'h1500);
        state_i = 4'h0;

        // Reset asserted during the RESP cycle of an accepted trigger
        @(negedge clk);
        ctrl_valid_i = 1'b1;
        ctrl_wen_i   = 1'b1;
        ctrl_addr_i  = 32'h0;
        ctrl_data_i  = 32'h3;
        @(posedge clk);
        #1;
        check("pre_rst_tvalid", {63'b0, trigger_valid_o}, 64'd1);
        rst = 1'b1;
        ctrl_valid_i = 1'b0;
        @(negedge clk);
        check("midrst_ready",  {63'b0, ctrl_ready_o}, 64'd0);
        check("midrst_tvalid", {63'b0, trigger_valid_o}, 64'd0);
        check("midrst_active", active_cfg_o[63:0], 64'd0);
        check("midrst_err",    {63'b0, err_o}, 64'd0);
        rst = 1'b0;
        xfer(1'b0, 32'h04, 32'h0);
        check("post_rst_shadow", {32'b0, s_rdata}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
